lp_pd_seq_ctrl: RTL and testbench
=================================

Name: lp_pd_seq_ctrl

Overview:
- Power-domain sequencing controller for one switchable domain.
- Orders isolation enable, retention save/restore and the power-switch enable, so the isolation checkers never see corrupted isolation outputs during a power transition.
- Sits in the always-on domain, between the power-management request logic and the domain's isolation cells, retention flops and header switch.
- All outputs are registered and glitch-free.

Parameters:
- ISO_SETUP_CYC, 2: cycles `iso_en` is held before save/switch-off, and also before isolation release after restore.
- RET_PULSE_CYC, 1: width in cycles of the `save` and `restore` pulses (minimum 1).
- SW_TIMEOUT, 255: maximum cycles to wait for `sw_ack` after toggling `pwr_sw_en`.
- CNT_W, 8: timer width. Must satisfy 2^CNT_W > max(ISO_SETUP_CYC, RET_PULSE_CYC, SW_TIMEOUT).

Ports:
- clk, input, 1: always-on clock.
- rst_n, input, 1: asynchronous active-low reset.
- pd_down_req, input, 1: level request to power the domain down.
- pd_up_req, input, 1: level request to power the domain up.
- sw_ack, input, 1: power-switch feedback; 1 = supply on, 0 = supply off. Synchronised externally.
- iso_en, output, 1: isolation enable for all isolation cells of the domain.
- save, output, 1: retention save pulse.
- restore, output, 1: retention restore pulse.
- pwr_sw_en, output, 1: header switch enable; 1 = supply connected.
- pd_on, output, 1: domain fully on and de-isolated.
- busy, output, 1: a sequence is in progress.
- seq_done, output, 1: one-cycle pulse when a sequence completes.
- sw_err, output, 1: sticky switch-timeout error.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = ON.
  - `pwr_sw_en`=1, `pd_on`=1; `iso_en`, `save`, `restore`, `busy`, `seq_done`, `sw_err` = 0; timer = 0.
  - Reset mid-sequence returns to ON immediately. This is intentional: the power-on reset of the always-on domain owns the supply state.
- States: ON, ISO_ON, SAVE, SW_OFF, OFF, SW_ON, RESTORE, ISO_OFF.
- Requests are sampled only in ON and OFF:
  - ON honours only `pd_down_req`; OFF honours only `pd_up_req`.
  - Both requests high in ON means down; in OFF means up.
  - Requests in any other state are ignored, not queued.
- Power-down sequence:
  - ON + `pd_down_req` -> ISO_ON: `iso_en`=1 and `pd_on`=0 in the next cycle.
  - ISO_ON holds ISO_SETUP_CYC cycles -> SAVE.
  - SAVE: `save`=1 for RET_PULSE_CYC cycles -> SW_OFF.
  - SW_OFF: `pwr_sw_en`=0. Wait for `sw_ack`==0 -> OFF, with `seq_done` pulsed in the OFF-entry cycle.
  - With defaults, `seq_done` occurs 1+2+1+1 cycles after the request when `sw_ack` falls in the first SW_OFF cycle.
- Power-up sequence:
  - OFF + `pd_up_req` -> SW_ON: `pwr_sw_en`=1. Wait for `sw_ack`==1 -> RESTORE.
  - RESTORE: `restore`=1 for RET_PULSE_CYC cycles -> ISO_OFF.
  - ISO_OFF holds `iso_en`=1 for ISO_SETUP_CYC cycles.
  - Then -> ON: `iso_en`=0, `pd_on`=1, `seq_done` pulsed.
- Invariants:
  - `iso_en`=1 in every state except ON.
  - `save` and `restore` are never high together, and never high while `pwr_sw_en`=0.
  - `busy`=1 in every state except ON and OFF.
- Timeout:
  - The timer counts in SW_OFF/SW_ON. If it reaches SW_TIMEOUT without the expected `sw_ack`, `sw_err` sets (sticky until reset).
  - SW_OFF timeout -> OFF anyway, with `pwr_sw_en` remaining 0.
  - SW_ON timeout -> OFF with `pwr_sw_en` returned to 0 and `iso_en` held.
  - `seq_done` is not pulsed on a timeout.
- `sw_ack` already at the target value on entry to SW_OFF/SW_ON: exit after one cycle in that state.
- Timer: unsigned, cleared on every state change, saturates at 2^CNT_W-1.

Optional Feature:
- Macro: LP_PD_SEQ_RETENTION_EN.
- Defined: SAVE and RESTORE states exist as above.
- Undefined:
  - SAVE and RESTORE are bypassed: ISO_ON -> SW_OFF, and SW_ON -> ISO_OFF.
  - `save`/`restore` are tied to 0.
  - Power-down latency shrinks by RET_PULSE_CYC cycles, and likewise power-up.

Decomposition:
- Shared package `lp_seq_pkg`:
  - `pd_seq_state_e` enum (3-bit).
  - Default constants for ISO_SETUP_CYC, RET_PULSE_CYC and SW_TIMEOUT.
  - Error code constant for switch timeout, used by the LP message layer.
- Sub-module `lp_seq_timer`: loadable/clearable saturating down-counter with a done flag. It is shared with future multi-domain sequencers.
- The FSM and output registers stay in the top module.

Test Plan:
- Down, `sw_ack` follows `pwr_sw_en` after 3 cycles; pulse `pd_down_req` for 1 cycle -> `iso_en`↑ at cycle 1, `save` high at cycle 3, `pwr_sw_en`↓ at cycle 4, `seq_done` at cycle 8, `pd_on`=0, `sw_err`=0.
- Up from OFF, `sw_ack` rises 3 cycles after `pwr_sw_en` -> `restore` pulses 1 cycle after `sw_ack`, `iso_en` deasserts 2 cycles after the `restore` pulse, `pd_on`=1, `seq_done` pulsed once.
- Hold `sw_ack`=1 through SW_OFF -> `sw_err`=1 exactly SW_TIMEOUT(255) cycles after SW_OFF entry, state OFF, no `seq_done`.
- Both requests high in ON -> down sequence runs. `pd_up_req` pulsed mid-sequence -> ignored; ends in OFF.
- Assert `rst_n`=0 during SAVE -> same-time return to reset values (`pwr_sw_en`=1, `iso_en`=0, `pd_on`=1).
- Build without LP_PD_SEQ_RETENTION_EN -> `save`/`restore` never toggle; down `seq_done` at cycle 7 in the scenario of the first test.

Source files
------------

// File: rtl/lp_seq_pkg.sv
// Shared state encoding, default timing constants and error codes for the
// low-power domain sequencers.
package lp_seq_pkg;

  typedef enum logic [2:0] {
    PD_ON      = 3'd0,
    PD_ISO_ON  = 3'd1,
    PD_SAVE    = 3'd2,
    PD_SW_OFF  = 3'd3,
    PD_OFF     = 3'd4,
    PD_SW_ON   = 3'd5,
    PD_RESTORE = 3'd6,
    PD_ISO_OFF = 3'd7
  } pd_seq_state_e;

  localparam int unsigned ISO_SETUP_CYC_DEF = 32'd2;
  localparam int unsigned RET_PULSE_CYC_DEF = 32'd1;
  localparam int unsigned SW_TIMEOUT_DEF    = 32'd255;

  // Reported by the LP message layer when the header switch never acknowledges.
  localparam logic [7:0] LP_ERR_SW_TIMEOUT = 8'h01;

  function automatic logic isBusyState(input logic [2:0] st);
    return !((st == PD_ON) || (st == PD_OFF));
  endfunction

endpackage

// File: rtl/lp_seq_timer.sv
// Loadable, clearable down-counter that saturates at zero; done flags zero.
module lp_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] loadVal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Load has priority over clear; counting stops once zero is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= loadVal;
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (count != {CNT_W{1'b0}}) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign done = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/lp_pd_seq_ctrl.sv
// Power-domain sequencer: orders isolation, retention and header switch.
// Define LP_PD_SEQ_RETENTION_EN to include the SAVE/RESTORE retention phases.
module lp_pd_seq_ctrl
  import lp_seq_pkg::*;
#(
  parameter int unsigned ISO_SETUP_CYC = ISO_SETUP_CYC_DEF,
  parameter int unsigned RET_PULSE_CYC = RET_PULSE_CYC_DEF,
  parameter int unsigned SW_TIMEOUT    = SW_TIMEOUT_DEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pd_down_req,
  input  logic pd_up_req,
  input  logic sw_ack,
  output logic iso_en,
  output logic save,
  output logic restore,
  output logic pwr_sw_en,
  output logic pd_on,
  output logic busy,
  output logic seq_done,
  output logic sw_err
);

  localparam logic [2:0] ST_ON      = PD_ON;
  localparam logic [2:0] ST_ISO_ON  = PD_ISO_ON;
  localparam logic [2:0] ST_SAVE    = PD_SAVE;
  localparam logic [2:0] ST_SW_OFF  = PD_SW_OFF;
  localparam logic [2:0] ST_OFF     = PD_OFF;
  localparam logic [2:0] ST_SW_ON   = PD_SW_ON;
  localparam logic [2:0] ST_RESTORE = PD_RESTORE;
  localparam logic [2:0] ST_ISO_OFF = PD_ISO_OFF;

`ifdef LP_PD_SEQ_RETENTION_EN
  localparam logic [2:0] ST_AFTER_ISO = ST_SAVE;
  localparam logic [2:0] ST_AFTER_ACK = ST_RESTORE;
  localparam logic       RET_EN       = 1'b1;
`else
  localparam logic [2:0] ST_AFTER_ISO = ST_SW_OFF;
  localparam logic [2:0] ST_AFTER_ACK = ST_ISO_OFF;
  localparam logic       RET_EN       = 1'b0;
`endif

  logic [2:0]       state;
  logic [2:0]       nextState;
  logic             swTimeout;
  logic             tmrDone;
  logic             tmrLoad;
  logic             tmrClear;
  logic [CNT_W-1:0] tmrLoadVal;

  // A state lasting N cycles loads N-1 so done rises in its last cycle.
  function automatic logic [CNT_W-1:0] holdLoad(input int unsigned cyc);
    if (cyc == 32'd0) begin
      holdLoad = {CNT_W{1'b0}};
    end else begin
      holdLoad = CNT_W'(cyc - 32'd1);
    end
  endfunction

  // Sequencing decisions; requests are honoured only in ON and OFF.
  always_comb begin
    nextState = state;
    swTimeout = 1'b0;
    case (state)
      ST_ON:      if (pd_down_req) nextState = ST_ISO_ON; else nextState = state;
      ST_ISO_ON:  if (tmrDone) nextState = ST_AFTER_ISO; else nextState = state;
      ST_SAVE:    if (tmrDone) nextState = ST_SW_OFF; else nextState = state;
      ST_SW_OFF: begin
        if (!sw_ack) begin
          nextState = ST_OFF;
        end else if (tmrDone) begin
          nextState = ST_OFF;
          swTimeout = 1'b1;
        end else begin
          nextState = state;
        end
      end
      ST_OFF:     if (pd_up_req) nextState = ST_SW_ON; else nextState = state;
      ST_SW_ON: begin
        if (sw_ack) begin
          nextState = ST_AFTER_ACK;
        end else if (tmrDone) begin
          nextState = ST_OFF;
          swTimeout = 1'b1;
        end else begin
          nextState = state;
        end
      end
      ST_RESTORE: if (tmrDone) nextState = ST_ISO_OFF; else nextState = state;
      ST_ISO_OFF: if (tmrDone) nextState = ST_ON; else nextState = state;
      default:    nextState = ST_ON;
    endcase
  end

  // Timer reload value for the state being entered.
  always_comb begin
    tmrLoad = (nextState != state);
    case (nextState)
      ST_ISO_ON, ST_ISO_OFF: tmrLoadVal = holdLoad(ISO_SETUP_CYC);
      ST_SAVE, ST_RESTORE:   tmrLoadVal = holdLoad(RET_PULSE_CYC);
      ST_SW_OFF, ST_SW_ON:   tmrLoadVal = holdLoad(SW_TIMEOUT);
      default:               tmrLoadVal = {CNT_W{1'b0}};
    endcase
  end

  assign tmrClear = (state == ST_ON) || (state == ST_OFF);

  lp_seq_timer #(.CNT_W(CNT_W)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmrLoad),
    .clear   (tmrClear),
    .loadVal (tmrLoadVal),
    .done    (tmrDone)
  );

  // State and outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ON;
      iso_en    <= 1'b0;
      save      <= 1'b0;
      restore   <= 1'b0;
      pwr_sw_en <= 1'b1;
      pd_on     <= 1'b1;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
      sw_err    <= 1'b0;
    end else begin
      state     <= nextState;
      iso_en    <= (nextState != ST_ON);
      save      <= RET_EN & (nextState == ST_SAVE);
      restore   <= RET_EN & (nextState == ST_RESTORE);
      pwr_sw_en <= !((nextState == ST_SW_OFF) || (nextState == ST_OFF));
      pd_on     <= (nextState == ST_ON);
      busy      <= isBusyState(nextState);
      seq_done  <= ((state == ST_SW_OFF) && (nextState == ST_OFF) && !swTimeout) ||
                   ((state == ST_ISO_OFF) && (nextState == ST_ON));
      sw_err    <= sw_err | swTimeout;
    end
  end

endmodule

// File: tb/tb_lp_pd_seq_ctrl.sv
// Scoreboard bench for lp_pd_seq_ctrl: randomized sequences vs a phase-duration model.
module tb_lp_pd_seq_ctrl;

  localparam int ISO  = 2;
  localparam int RETP = 1;
  localparam int SWTO = 255;
`ifdef LP_PD_SEQ_RETENTION_EN
  localparam int RET = RETP;
`else
  localparam int RET = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pd_down_req = 1'b0;
  logic pd_up_req = 1'b0;
  logic sw_ack = 1'b1;
  logic iso_en, save, restore, pwr_sw_en, pd_on, busy, seq_done, sw_err;

  lp_pd_seq_ctrl #(
    .ISO_SETUP_CYC(ISO), .RET_PULSE_CYC(RETP), .SW_TIMEOUT(SWTO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pd_down_req(pd_down_req), .pd_up_req(pd_up_req),
    .sw_ack(sw_ack), .iso_en(iso_en), .save(save), .restore(restore),
    .pwr_sw_en(pwr_sw_en), .pd_on(pd_on), .busy(busy), .seq_done(seq_done),
    .sw_err(sw_err)
  );

  typedef struct {
    int reqCyc;
    int endRel;
    int pwrRel;
    int saves;
    int restores;
    int dones;
    bit pdOn;
    bit isoEn;
    bit pwrEn;
    bit err;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int ackLat = 0;
  bit ackStuck = 1'b0;
  bit hist[16];
  bit modelOn = 1'b1;
  bit modelErr = 1'b0;
  int saveCnt = 0, restCnt = 0, doneCnt = 0, pwrEdgeCyc = -1;
  logic prevPwr = 1'b1;
  logic prevBusy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function void chk(string name, int act, int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Switch model: sw_ack follows pwr_sw_en ackLat cycles later unless stuck.
  always @(negedge clk) begin
    hist[4'(cyc)] = pwr_sw_en;
    if (!ackStuck) sw_ack = hist[4'(cyc - ackLat)];
  end

  // Monitor: invariants every cycle, scoreboard pop on each sequence completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      saveCnt = 0; restCnt = 0; doneCnt = 0; pwrEdgeCyc = -1;
      prevPwr = pwr_sw_en; prevBusy = 1'b0;
    end else begin
      chk("inv_iso_vs_pd_on", int'(iso_en), int'(!pd_on));
      chk("inv_save_restore_excl", int'(save & restore), 0);
      chk("inv_ret_while_unpowered", int'((save | restore) & !pwr_sw_en), 0);
      chk("inv_busy_implies_iso", int'(busy & !iso_en), 0);
      if (save) saveCnt++;
      if (restore) restCnt++;
      if (seq_done) doneCnt++;
      if (pwr_sw_en !== prevPwr && pwrEdgeCyc < 0) pwrEdgeCyc = cyc;
      prevPwr = pwr_sw_en;
      if (prevBusy && !busy) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          monE = sbq.pop_front();
          chk("end_latency", cyc - monE.reqCyc, monE.endRel);
          chk("pwr_edge_latency", pwrEdgeCyc - monE.reqCyc, monE.pwrRel);
          chk("save_cycles", saveCnt, monE.saves);
          chk("restore_cycles", restCnt, monE.restores);
          chk("seq_done_pulses", doneCnt, monE.dones);
          chk("final_pd_on", int'(pd_on), int'(monE.pdOn));
          chk("final_iso_en", int'(iso_en), int'(monE.isoEn));
          chk("final_pwr_sw_en", int'(pwr_sw_en), int'(monE.pwrEn));
          chk("final_sw_err", int'(sw_err), int'(monE.err));
        end
        saveCnt = 0; restCnt = 0; doneCnt = 0; pwrEdgeCyc = -1;
      end
      prevBusy = busy;
    end
  end

  // Reference model: phase durations relative to the request-sampling cycle.
  function automatic exp_t model(bit up, int lat, bit stuck, int rc);
    exp_t e;
    bit ok;
    ok = !stuck && (lat < SWTO);
    e.reqCyc = rc;
    if (!up) begin
      e.pwrRel = 1 + ISO + RET;
      e.endRel = ok ? (1 + ISO + RET + lat + 1) : (1 + ISO + RET + SWTO);
      e.saves = RET; e.restores = 0; e.dones = ok ? 1 : 0;
      e.pdOn = 1'b0; e.isoEn = 1'b1; e.pwrEn = 1'b0;
    end else begin
      e.pwrRel = 1;
      e.saves = 0;
      if (ok) begin
        e.endRel = 2 + lat + RET + ISO; e.restores = RET; e.dones = 1;
        e.pdOn = 1'b1; e.isoEn = 1'b0; e.pwrEn = 1'b1;
      end else begin
        e.endRel = 1 + SWTO; e.restores = 0; e.dones = 0;
        e.pdOn = 1'b0; e.isoEn = 1'b1; e.pwrEn = 1'b0;
      end
    end
    e.err = modelErr | !ok;
    return e;
  endfunction

  task automatic waitDrain();
    for (int i = 0; i < 700 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("completion_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic runSeq(input int lat, input bit stuck, input bit other, input bit noise);
    exp_t e;
    bit up;
    ackStuck = 1'b0;
    repeat (20) @(negedge clk);
    ackLat = lat;
    ackStuck = stuck;
    @(negedge clk);
    up = !modelOn;
    e = model(up, lat, stuck, cyc);
    sbq.push_back(e);
    modelErr = e.err;
    modelOn = e.pdOn;
    if (up) begin pd_up_req = 1'b1; pd_down_req = other; end
    else begin pd_down_req = 1'b1; pd_up_req = other; end
    @(negedge clk);
    pd_down_req = 1'b0; pd_up_req = 1'b0;
    @(negedge clk);
    if (noise) begin
      if ($urandom_range(0, 1) == 1) pd_down_req = 1'b1; else pd_up_req = 1'b1;
    end
    @(negedge clk);
    pd_down_req = 1'b0; pd_up_req = 1'b0;
    waitDrain();
  endtask

  // Reset asserted in the cycle after isolation setup (SAVE when retention is built in).
  task automatic resetMidSeq();
    ackStuck = 1'b0;
    repeat (20) @(negedge clk);
    pd_down_req = 1'b1;
    @(negedge clk);
    pd_down_req = 1'b0;
    repeat (ISO) @(negedge clk);
    chk("save_before_rst", int'(save), RET);
    chk("pwr_before_rst", int'(pwr_sw_en), (RET > 0) ? 1 : 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pwr_sw_en", int'(pwr_sw_en), 1);
    chk("rst_iso_en", int'(iso_en), 0);
    chk("rst_pd_on", int'(pd_on), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_save", int'(save), 0);
    chk("rst_sw_err", int'(sw_err), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    modelOn = 1'b1;
    modelErr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hist[i] = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pwr_sw_en", int'(pwr_sw_en), 1);
    chk("reset_pd_on", int'(pd_on), 1);
    chk("reset_iso_en", int'(iso_en), 0);
    chk("reset_save", int'(save), 0);
    chk("reset_restore", int'(restore), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_seq_done", int'(seq_done), 0);
    chk("reset_sw_err", int'(sw_err), 0);

    runSeq(3, 1'b0, 1'b0, 1'b0);  // down, ack lags 3 cycles
    runSeq(3, 1'b0, 1'b0, 1'b0);  // up, ack lags 3 cycles
    runSeq(0, 1'b0, 1'b0, 1'b0);  // down, ack already at target
    runSeq(0, 1'b0, 1'b0, 1'b0);  // up, ack already at target
    runSeq(0, 1'b1, 1'b0, 1'b0);  // down, ack stuck high -> timeout
    runSeq(2, 1'b0, 1'b1, 1'b1);  // up, both requests, mid-sequence noise
    runSeq(1, 1'b0, 1'b1, 1'b1);  // down, both requests, mid-sequence noise
    runSeq(0, 1'b1, 1'b0, 1'b0);  // up, ack stuck low -> timeout, stays OFF
    runSeq(4, 1'b0, 1'b0, 1'b0);  // up
    resetMidSeq();

    for (int n = 0; n < 30; n++) begin
      runSeq(int'($urandom_range(0, 6)), ($urandom_range(0, 11) == 0),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
    $fatal(1);
  end

endmodule
